// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern frame transmitter.
package pattern_tx_pkg;

    localparam int COORD_W = 12;
    localparam int PIX_W   = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VFRONT = 3'd1,
        LINE   = 3'd2,
        HBLANK = 3'd3,
        VBACK  = 3'd4,
        FBLANK = 3'd5
    } state_t;

    localparam logic [2:0] PAT_ZERO  = 3'b000;
    localparam logic [2:0] PAT_ONES  = 3'b001;
    localparam logic [2:0] PAT_HGRAD = 3'b010;
    localparam logic [2:0] PAT_CHECK = 3'b011;
    localparam logic [2:0] PAT_VGRAD = 3'b100;
    localparam logic [2:0] PAT_DIAG  = 3'b101;
    localparam logic [2:0] PAT_COUNT = 3'b110;
    localparam logic [2:0] PAT_MID   = 3'b111;

endpackage

// File: rtl/pattern_pixel_gen.sv
// Combinational pixel value for the latched pattern at coordinate (x, y).
module pattern_pixel_gen
    import pattern_tx_pkg::*;
(
    input  logic [2:0]         sel,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [PIX_W-1:0]   pix_cnt,
    output logic [PIX_W-1:0]   pix
);

    // Only the low coordinate bits shape any pattern.
    logic unused_hi;
    assign unused_hi = ^{x[COORD_W-1:8], y[COORD_W-1:8]};

    always_comb begin
        pix = '0;
        case (sel)
            PAT_ZERO:  pix = 8'h00;
            PAT_ONES:  pix = 8'hFF;
            PAT_HGRAD: pix = x[7:0];
            PAT_CHECK: pix = (x[5] ^ y[5]) ? 8'hFF : 8'h00;
            PAT_VGRAD: pix = y[7:0];
            PAT_DIAG:  pix = x[7:0] + y[7:0];
            PAT_COUNT: pix = pix_cnt;
            PAT_MID:   pix = 8'h80;
            default:   pix = 8'h00;
        endcase
    end

endmodule

// File: rtl/pattern_frame_tx.sv
// Frame/line timing generator with selectable test patterns. Every output is a
// flop driven from the state of the previous cycle, so outputs trail the state
// by one cycle; back-to-back frame period is exact, a frame from IDLE starts one cycle after en.
module pattern_frame_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 16,
    parameter int V_FRONT = 4,
    parameter int V_BACK  = 4,
    parameter int F_BLANK = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic             stall,
    output logic             fval,
    output logic             lval,
    output logic             dval,
    output logic [PIX_W-1:0] pix_data,
    output logic             frame_done,
    output state_t           state_dbg
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]   VF_LAST = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0]   HB_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]   VB_LAST = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0]   FB_LAST = CNT_W'(F_BLANK - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [PIX_W-1:0]   pix_cnt;
    logic [2:0]         sel_q;
    logic [PIX_W-1:0]   pix_val;
    logic               start_frame;

    // en only matters in IDLE and on the final FBLANK cycle.
    assign start_frame = en && ((state == IDLE) || (state == FBLANK && cnt == FB_LAST));
    assign state_dbg   = state;

    pattern_pixel_gen u_pix (
        .sel     (sel_q),
        .x       (x),
        .y       (y),
        .pix_cnt (pix_cnt),
        .pix     (pix_val)
    );

    // Flow control: a LINE cycle with stall low delivers pixel (x,y) next cycle
    // with dval high; with stall high nothing moves and lval stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            x          <= '0;
            y          <= '0;
            pix_cnt    <= '0;
            sel_q      <= '0;
            fval       <= 1'b0;
            lval       <= 1'b0;
            dval       <= 1'b0;
            pix_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            fval       <= (state != IDLE) && (state != FBLANK);
            lval       <= 1'b0;
            dval       <= 1'b0;
            pix_data   <= '0;
            frame_done <= (state == FBLANK) && (cnt == '0);

            if (start_frame) begin
                state   <= VFRONT;
                sel_q   <= sel;
                x       <= '0;
                y       <= '0;
                cnt     <= '0;
                pix_cnt <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    VFRONT: begin
                        if (cnt == VF_LAST) begin
                            cnt   <= '0;
                            state <= LINE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    LINE: begin
                        lval <= 1'b1;
                        if (!stall) begin
                            dval     <= 1'b1;
                            pix_data <= pix_val;
                            pix_cnt  <= pix_cnt + PIX_W'(1);
                            if (x == X_LAST) begin
                                x <= '0;
                                if (y == Y_LAST) begin
                                    state <= VBACK;
                                end else begin
                                    y     <= y + COORD_W'(1);
                                    state <= HBLANK;
                                end
                            end else begin
                                x <= x + COORD_W'(1);
                            end
                        end
                    end
                    HBLANK: begin
                        if (cnt == HB_LAST) begin
                            cnt   <= '0;
                            state <= LINE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    VBACK: begin
                        if (cnt == VB_LAST) begin
                            cnt   <= '0;
                            state <= FBLANK;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    FBLANK: begin
                        if (cnt == FB_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Self-checking bench for pattern_frame_tx: scoreboarded pixels plus frame/line timing monitor.
`timescale 1ns/1ps
module tb_pattern_frame_tx;
    import pattern_tx_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int HB = 2;
    localparam int VF = 3;
    localparam int VB = 3;
    localparam int FB = 5;
    localparam int BW = 64;
    localparam int BH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [2:0] sel;
    logic       stall = 1'b0;
    logic       stall_tog = 1'b0;
    logic       fval, lval, dval, frame_done;
    logic [7:0] pix_data;
    state_t     state_dbg;

    logic       b_en;
    logic [2:0] b_sel;
    logic       b_stall;
    logic       b_fval, b_lval, b_dval, b_done;
    logic [7:0] b_pix;
    state_t     b_state;

    pattern_frame_tx #(
        .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_FRONT(VF), .V_BACK(VB), .F_BLANK(FB)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .stall(stall),
        .fval(fval), .lval(lval), .dval(dval), .pix_data(pix_data),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    pattern_frame_tx #(
        .WIDTH(BW), .HEIGHT(BH), .H_BLANK(HB), .V_FRONT(VF), .V_BACK(VB), .F_BLANK(FB)
    ) dut_big (
        .clk(clk), .rst(rst), .en(b_en), .sel(b_sel), .stall(b_stall),
        .fval(b_fval), .lval(b_lval), .dval(b_dval), .pix_data(b_pix),
        .frame_done(b_done), .state_dbg(b_state)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix_model(input logic [2:0] s, input int x, input int y, input int n);
        logic [11:0] xs;
        logic [11:0] ys;
        xs = 12'(x);
        ys = 12'(y);
        case (s)
            3'b000:  return 8'h00;
            3'b001:  return 8'hFF;
            3'b010:  return xs[7:0];
            3'b011:  return (xs[5] ^ ys[5]) ? 8'hFF : 8'h00;
            3'b100:  return ys[7:0];
            3'b101:  return 8'((x + y) % 256);
            3'b110:  return 8'(n % 256);
            default: return 8'h80;
        endcase
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] big_q[$];

    task automatic push_frame(input logic [2:0] s);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                exp_q.push_back(pix_model(s, xx, yy, yy * W + xx));
    endtask

    // ---------------- drivers ----------------
    always @(negedge clk) stall = stall_tog ? ~stall : 1'b0;

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_en(input int cycles);
        @(negedge clk);
        en = 1'b1;
        repeat (cycles) @(negedge clk);
        en = 1'b0;
    endtask

    // ---------------- monitor / scoreboard (small DUT) ----------------
    bit mon_on = 1'b0;
    bit seen_lval, prev_fval, prev_lval;
    int pre_cnt, gap_cnt, line_dvals, line_count, frame_pix;
    int fval_low = 0;
    int last_gap = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (!mon_on) begin
            seen_lval = 0; pre_cnt = 0; gap_cnt = 0;
            line_dvals = 0; line_count = 0; frame_pix = 0;
        end else begin
            check("dval_needs_lval", dval & ~lval, 1'b0);
            check("lval_needs_fval", lval & ~fval, 1'b0);
            check("done_at_fval_fall", frame_done, prev_fval & ~fval);
            if (dval) begin
                check("pix_q_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("pix", pix_data, exp_q.pop_front());
                line_dvals++;
                frame_pix++;
            end else begin
                check("pix_zero_no_dval", pix_data, 8'h00);
            end
            if (lval && !prev_lval) begin
                if (!seen_lval) check("v_front", pre_cnt, VF);
                else            check("h_blank", gap_cnt, HB);
                seen_lval = 1;
            end
            if (!lval && prev_lval) begin
                check("line_len", line_dvals, W);
                line_dvals = 0;
                line_count++;
            end
            if (fval && !lval) begin
                if (seen_lval) gap_cnt++;
                else           pre_cnt++;
            end
            if (lval) gap_cnt = 0;
            if (!fval && prev_fval) begin
                check("v_back", gap_cnt, VB);
                check("frame_pix", frame_pix, W * H);
                seen_lval = 0; pre_cnt = 0; gap_cnt = 0;
                frame_pix = 0; line_count = 0;
            end
        end
        if (!fval) fval_low++;
        if (fval && !prev_fval) last_gap = fval_low;
        if (fval) fval_low = 0;
        prev_fval = fval;
        prev_lval = lval;
    end

    // ---------------- monitor / scoreboard (64x64 DUT) ----------------
    int bx = 0;
    int by = 0;
    int b_done_cnt = 0;
    logic [7:0] cap_0_0 = 8'h5A, cap_32_0 = 8'h5A, cap_0_32 = 8'h5A;
    logic [7:0] cap_32_32 = 8'h5A, cap_63_63 = 8'h5A;

    always @(negedge clk) begin
        if (b_done) b_done_cnt++;
        if (b_dval) begin
            check("big_q_nonempty", big_q.size() != 0, 1'b1);
            if (big_q.size() != 0) check("big_pix", b_pix, big_q.pop_front());
            if (bx == 0  && by == 0)  cap_0_0   = b_pix;
            if (bx == 32 && by == 0)  cap_32_0  = b_pix;
            if (bx == 0  && by == 32) cap_0_32  = b_pix;
            if (bx == 32 && by == 32) cap_32_32 = b_pix;
            if (bx == 63 && by == 63) cap_63_63 = b_pix;
            if (bx == BW - 1) begin
                bx = 0;
                by++;
            end else begin
                bx++;
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_wait", done_cnt >= target, 1'b1);
    endtask

    task automatic wait_fval_rise(input int budget);
        int n = 0;
        while (!fval && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fval_rise_wait", fval, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int n;
        rst = 1'b1; en = 1'b0; sel = 3'b000;
        b_en = 1'b0; b_sel = 3'b000; b_stall = 1'b0;
        idle_cycles(3);
        check("rst_fval", fval, 1'b0);
        check("rst_lval", lval, 1'b0);
        check("rst_dval", dval, 1'b0);
        check("rst_pix", pix_data, 8'h00);
        check("rst_done", frame_done, 1'b0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;

        // single frame, horizontal gradient, one-cycle en pulse
        sel = 3'b010;
        push_frame(3'b010);
        d0 = done_cnt;
        pulse_en(1);
        wait_done(d0 + 1, 200);
        check("t035_q_empty", exp_q.size(), 0);
        idle_cycles(20);
        check("t035_idle", state_dbg, IDLE);
        check("t035_fval_low", fval, 1'b0);
        check("t035_one_done", done_cnt, d0 + 1);

        // per-frame pixel counter under alternating stall
        sel = 3'b110;
        push_frame(3'b110);
        d0 = done_cnt;
        stall_tog = 1'b1;
        pulse_en(1);
        wait_done(d0 + 1, 400);
        stall_tog = 1'b0;
        check("t037_q_empty", exp_q.size(), 0);
        idle_cycles(20);

        // en held, sel changed mid-frame takes effect next frame
        sel = 3'b000;
        push_frame(3'b000);
        push_frame(3'b001);
        d0 = done_cnt;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (line_count != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t038_line2_seen", line_count, 1);
        sel = 3'b001;
        wait_done(d0 + 1, 200);
        wait_fval_rise(50);
        en = 1'b0;
        @(negedge clk);
        check("t038_fval_gap", last_gap, FB);
        wait_done(d0 + 2, 200);
        idle_cycles(20);
        check("t038_idle", state_dbg, IDLE);
        check("t038_two_done", done_cnt, d0 + 2);
        check("t038_q_empty", exp_q.size(), 0);

        // reset in the middle of line 1
        sel = 3'b010;
        push_frame(3'b010);
        pulse_en(1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(dval && pix_data == 8'h03 && line_count == 1) && n < 200);
        check("t039_hit_3_1", dval && pix_data == 8'h03 && line_count == 1, 1'b1);
        mon_on = 1'b0;
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t039_fval", fval, 1'b0);
        check("t039_lval", lval, 1'b0);
        check("t039_dval", dval, 1'b0);
        check("t039_pix", pix_data, 8'h00);
        check("t039_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(10);
        check("t039_no_done", done_cnt, d0);
        check("t039_idle", state_dbg, IDLE);
        exp_q.delete();
        mon_on = 1'b1;
        push_frame(3'b010);
        pulse_en(1);
        wait_done(d0 + 1, 200);
        check("t039_q_empty", exp_q.size(), 0);
        idle_cycles(10);

        // en dropped during VFRONT: frame completes, no second frame
        sel = 3'b101;
        push_frame(3'b101);
        d0 = done_cnt;
        pulse_en(2);
        check("t040_in_vfront", state_dbg, VFRONT);
        wait_done(d0 + 1, 200);
        idle_cycles(30);
        check("t040_idle", state_dbg, IDLE);
        check("t040_fval_low", fval, 1'b0);
        check("t040_one_done", done_cnt, d0 + 1);
        check("t040_q_empty", exp_q.size(), 0);

        // 64x64 checkerboard
        for (int yy = 0; yy < BH; yy++)
            for (int xx = 0; xx < BW; xx++)
                big_q.push_back(pix_model(3'b011, xx, yy, 0));
        b_sel = 3'b011;
        @(negedge clk);
        b_en = 1'b1;
        @(negedge clk);
        b_en = 1'b0;
        n = 0;
        while (b_done_cnt < 1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("t036_done", b_done_cnt, 1);
        check("t036_q_empty", big_q.size(), 0);
        check("t036_0_0", cap_0_0, 8'h00);
        check("t036_32_0", cap_32_0, 8'hFF);
        check("t036_0_32", cap_0_32, 8'hFF);
        check("t036_32_32", cap_32_32, 8'h00);
        check("t036_63_63", cap_63_63, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_frame_tx.md
PATTERN_FRAME_TX -- requirements
Module: pattern_frame_tx

Interface
REQ-001 Parameter WIDTH, default 640: active pixels per line, range 1..4096.
REQ-002 Parameter HEIGHT, default 480: active lines per frame, range 1..4096.
REQ-003 Parameter H_BLANK, default 16: lval-low cycles between lines within a frame, minimum 1.
REQ-004 Parameter V_FRONT, default 4: cycles from fval rise to first lval rise, minimum 1.
REQ-005 Parameter V_BACK, default 4: cycles from last lval fall to fval fall, minimum 1.
REQ-006 Parameter F_BLANK, default 32: minimum fval-low cycles between frames, minimum 1.
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 en  input  1  frame request; sampled only in IDLE and at the end of FBLANK.
REQ-010 sel  input  3  pattern select; latched at frame start.
REQ-011 stall  input  1  pixel hold; while high in a line, no pixel is emitted.
REQ-012 fval  output  1  frame valid.
REQ-013 lval  output  1  line valid.
REQ-014 dval  output  1  data valid; one pixel per dval-high cycle.
REQ-015 pix_data  output  8  pixel value; 0x00 whenever dval is low.
REQ-016 frame_done  output  1  single-cycle pulse in the cycle fval falls.

Function
REQ-017 All outputs SHALL be flip-flop outputs, with no combinational path from any input to any output.
REQ-018 The state machine SHALL have states IDLE, VFRONT, LINE, HBLANK, VBACK, FBLANK.
REQ-019 IDLE: all outputs 0; en high at a clock edge -> VFRONT at that edge, with sel latched and x=0, y=0.
REQ-020 VFRONT: fval=1, lval=0 for exactly V_FRONT cycles -> LINE.
REQ-021 LINE: fval=1, lval=1; an edge with stall low emits pixel (x,y) with dval=1 in the following cycle and increments x; an edge with stall high gives dval=0 in the following cycle, with x held and lval held high.
REQ-022 Each line SHALL contain exactly WIDTH dval-high cycles, and lval SHALL be continuously high from the first to the last dval cycle of the line inclusive.
REQ-023 dval SHALL never be high while lval is low, and lval SHALL never be high while fval is low.
REQ-024 The last pixel of a line (x=WIDTH-1) SHALL clear x; then if y=HEIGHT-1 -> VBACK, else y increments -> HBLANK.
REQ-025 HBLANK: lval=0, fval=1 for exactly H_BLANK cycles -> LINE.
REQ-026 VBACK: fval=1, lval=0 for exactly V_BACK cycles; fval then falls, frame_done pulses in that same cycle -> FBLANK.
REQ-027 FBLANK: fval=0 for exactly F_BLANK cycles; then en high -> VFRONT (sel relatched), else -> IDLE.
REQ-028 en deasserting mid-frame SHALL NOT truncate the frame, and a sel change mid-frame SHALL take effect only at the next frame start.
REQ-029 Patterns, with x and y taken from 12-bit counters:
- 000 = 0x00.
- 001 = 0xFF.
- 010 = x[7:0] (horizontal gradient, wraps every 256).
- 011 = 0xFF if (x[5]^y[5]), else 0x00 (32x32 checkers).
- 100 = y[7:0].
- 101 = (x+y)[7:0] (diagonal).
- 110 = per-frame pixel counter mod 256, cleared at frame start.
- 111 = 0x80.
REQ-030 With stall low, frame period SHALL be V_FRONT + HEIGHT*WIDTH + (HEIGHT-1)*H_BLANK + V_BACK + F_BLANK cycles, ±1 cycle of output registration, fixed by the implementation and documented.

Reset
REQ-031 rst high SHALL force state IDLE and clear x, y, the cycle counter, the latched sel and all outputs to 0 asynchronously.
REQ-032 rst asserted mid-line or mid-frame SHALL abort the frame with no frame_done pulse; after release, the block waits in IDLE for en.

Structure
REQ-033 A shared package pattern_tx_pkg SHALL hold the state enumeration, 3-bit pattern code constants and the 12-bit coordinate width constant.
REQ-034 One sub-module, pattern_pixel_gen, SHALL compute pix value from (sel_latched, x, y, pixel counter) combinationally; the timing FSM and all counters stay in pattern_frame_tx.

Verification
Bench parameters: WIDTH=8, HEIGHT=4, H_BLANK=2, V_FRONT=3, V_BACK=3, F_BLANK=5 unless noted.
REQ-035 en pulse 1 cycle in IDLE, sel=010, stall=0 -> one frame:
- 4 lines, each pix 0..7.
- lval gaps of exactly 2 cycles.
- fval high 3 cycles before the first lval and 3 cycles after the last lval.
- one frame_done pulse, then IDLE.
REQ-036 WIDTH=64, HEIGHT=64, sel=011 -> pix:
- (0,0)=0x00, (32,0)=0xFF, (0,32)=0xFF, (32,32)=0x00, (63,63)=0x00.
REQ-037 sel=110, stall toggling 1-high/1-low through the frame:
- each line still has 8 dval cycles.
- pix increments 0..31 contiguously.
- lval never drops inside a line.
- pix_data=0 on dval-low cycles.
REQ-038 en held high, sel changed 000->001 during line 2:
- frame 1 all 0x00.
- frame 2 all 0xFF.
- fval low exactly 5 cycles between frames.
REQ-039 rst asserted at pixel (3,1) -> next cycle fval=lval=dval=0, pix_data=0, no frame_done; after release with en=1 -> a new full frame starting at (0,0).
REQ-040 en deasserted during VFRONT of frame 1 -> frame 1 completes fully (32 pixels), then IDLE, with no second frame.
